// File: rtl/fetch_queue_unit.sv
//==============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction fetch stage with a small {PC, instruction} queue.
//            The PC register addresses a combinational instruction memory;
//            each accepted fetch is pushed into a circular FIFO whose head
//            is presented to decode. Handles branch waits, redirects with
//            a configurable number of bubble cycles, and a global freeze.
//            All state updates on the FALLING edge of I_CLOCK.
// Ports    : I_CLOCK, I_RESET (sync, active-high)
//            O_IMemAddr / I_IMemData    - instruction memory read port
//            I_BranchPC / I_BranchAddrSelect - redirect target and strobe
//            I_BranchStallSignal        - decode holds an unresolved branch
//            I_DepStallSignal           - decode cannot accept head entry
//            I_GPUStallSignal           - global pipeline freeze
//            O_PC / O_IR / O_FE_Valid   - queue head toward decode
//            O_QueueCount               - occupied entries
//            O_StallCycles / O_FlushCount - performance counters
// Options  : define FETCH_PERF_CNT_EN to build the performance counters;
//            otherwise both counter ports are tied to zero.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_queue_unit #(
  parameter int                  PC_WIDTH       = 16,
  parameter int                  IR_WIDTH       = 32,
  parameter int                  QUEUE_DEPTH    = 4,
  parameter int                  BRANCH_BUBBLES = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                             I_CLOCK,
  input  logic                             I_RESET,
  output logic [PC_WIDTH-1:0]              O_IMemAddr,
  input  logic [IR_WIDTH-1:0]              I_IMemData,
  input  logic [PC_WIDTH-1:0]              I_BranchPC,
  input  logic                             I_BranchAddrSelect,
  input  logic                             I_BranchStallSignal,
  input  logic                             I_DepStallSignal,
  input  logic                             I_GPUStallSignal,
  output logic [PC_WIDTH-1:0]              O_PC,
  output logic [IR_WIDTH-1:0]              O_IR,
  output logic                             O_FE_Valid,
  output logic [$clog2(QUEUE_DEPTH):0]     O_QueueCount,
  output logic [31:0]                      O_StallCycles,
  output logic [31:0]                      O_FlushCount
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_BR_WAIT = 2'd1;
  localparam logic [1:0] ST_BUBBLE  = 2'd2;

  localparam logic [IR_WIDTH-1:0] NOP_IR      = IR_WIDTH'(32'hFF00_0000);
  localparam logic [CNT_W-1:0]    DEPTH_C     = CNT_W'(QUEUE_DEPTH);
  localparam logic [2:0]          BUBBLE_INIT = 3'(BRANCH_BUBBLES);
  localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] pc;
  logic [1:0]          state;
  logic [2:0]          bub_cnt;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;

  logic [PC_WIDTH-1:0] pc_mem [QUEUE_DEPTH];
  logic [IR_WIDTH-1:0] ir_mem [QUEUE_DEPTH];

  logic valid;
  logic pop;
  logic push;

  // Reset is folded into valid so the head is hidden while reset is held,
  // even before the first falling edge has cleared the queue.
  assign valid = (count != '0) && (state == ST_RUN) && !I_RESET;
  assign pop   = valid && !I_DepStallSignal && !I_GPUStallSignal;

  // A full queue may still accept a fetch when the head leaves in the same
  // cycle; the slot being freed is the one the write pointer lands on.
  assign push  = (state == ST_RUN) && ((count < DEPTH_C) || pop) &&
                 !I_BranchStallSignal && !I_GPUStallSignal &&
                 !I_BranchAddrSelect;

  assign O_IMemAddr   = pc;
  assign O_FE_Valid   = valid;
  assign O_PC         = valid ? pc_mem[rd_ptr] : '0;
  assign O_IR         = valid ? ir_mem[rd_ptr] : NOP_IR;
  assign O_QueueCount = count;

  // Queue storage carries no reset; occupancy alone decides what is live.
  always_ff @(negedge I_CLOCK) begin
    if (push && !I_RESET) begin
      pc_mem[wr_ptr] <= pc;
      ir_mem[wr_ptr] <= I_IMemData;
    end
  end

  // Control: reset > redirect > freeze > branch stall > normal push/pop.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      pc      <= RESET_PC;
      state   <= ST_RUN;
      bub_cnt <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (I_BranchAddrSelect) begin
      pc     <= I_BranchPC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (BRANCH_BUBBLES == 0) begin
        state   <= ST_RUN;
        bub_cnt <= '0;
      end else begin
        state   <= ST_BUBBLE;
        bub_cnt <= BUBBLE_INIT;
      end
    end else if (I_GPUStallSignal) begin
      // Frozen: everything holds.
      state <= state;
    end else begin
      case (state)
        ST_BR_WAIT: begin
          // Not-taken resolution: resume at the held PC.
          if (!I_BranchStallSignal) begin
            state <= ST_RUN;
          end
        end
        ST_BUBBLE: begin
          // Leaving once the decremented value reaches 1 yields
          // BRANCH_BUBBLES invalid cycles after the redirect edge.
          bub_cnt <= bub_cnt - 3'd1;
          if (bub_cnt <= 3'd2) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (I_BranchStallSignal) begin
            state  <= ST_BR_WAIT;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
          end else begin
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
              pc     <= pc + PC_STEP;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
              count <= count + 1'b1;
            end else if (pop && !push) begin
              count <= count - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        stall_event;
  logic        flush_event;

  // A head entry was offered but could not leave.
  assign stall_event = valid && (I_DepStallSignal || I_GPUStallSignal);

  // Only flushes that actually discard entries are counted.
  assign flush_event = !I_RESET && (count != '0) &&
                       (I_BranchAddrSelect ||
                        (!I_GPUStallSignal && (state == ST_RUN) &&
                         I_BranchStallSignal));

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_event && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_event && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

  assign O_StallCycles = stall_cycles;
  assign O_FlushCount  = flush_count;
`else
  assign O_StallCycles = '0;
  assign O_FlushCount  = '0;
`endif

endmodule

`default_nettype wire
